// File: rtl/gate_access_ctrl.sv
// gate_access_ctrl
//   Multi-lane gate controller. Each lane takes digits serially from its keypad
//   while a car is present, compares them with PASSCODE, and on a match raises
//   a timed unlock pulse. MAX_TRIES consecutive failures give a timed lockout.
//   Lanes are fully independent (one generate instance each).
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   car_detected in   [N_LANES]          per-lane vehicle presence (level)
//   digit_valid  in   [N_LANES]          per-lane one-cycle digit strobe
//   digit_data   in   [N_LANES*DIGIT_W]  lane i digit at [i*DIGIT_W +: DIGIT_W]
//   unlock       out  [N_LANES]          registered barrier-open command
//   locked_out   out  [N_LANES]          registered lockout indicator
//   busy         out  [N_LANES]          registered, lane not in IDLE
//   grant_count  out  [N_LANES*8]        per-lane saturating grant counter
//
// Optional feature macro: GATE_AUDIT_CNT_EN
//   defined   -> grant_count counts CHECK->OPEN transitions, saturating at 255
//   undefined -> grant_count is tied to 0 (port list unchanged)
module gate_access_ctrl #(
  parameter int N_LANES        = 2,
  parameter int CODE_DIGITS    = 3,
  parameter int DIGIT_W        = 4,
  parameter logic [CODE_DIGITS*DIGIT_W-1:0] PASSCODE = 12'h123,
  parameter int OPEN_CYCLES    = 8,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int ENTRY_TIMEOUT  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_LANES-1:0]           car_detected,
  input  logic [N_LANES-1:0]           digit_valid,
  input  logic [N_LANES*DIGIT_W-1:0]   digit_data,
  output logic [N_LANES-1:0]           unlock,
  output logic [N_LANES-1:0]           locked_out,
  output logic [N_LANES-1:0]           busy,
  output logic [N_LANES*8-1:0]         grant_count
);

  localparam int IDX_W = $clog2(CODE_DIGITS + 1);
  localparam int GAP_W = $clog2(ENTRY_TIMEOUT + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int OPN_W = $clog2(OPEN_CYCLES + 1);
  localparam int LCK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_DIGITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(ENTRY_TIMEOUT - 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [OPN_W-1:0] OPN_LAST = OPN_W'(OPEN_CYCLES - 1);
  localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_WAIT_CLEAR,
    S_LOCKOUT
  } state_e;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mis_q, mis_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [OPN_W-1:0]   open_q, open_d;
    logic [LCK_W-1:0]   lock_q, lock_d;
    logic               unlock_q, unlock_d;
    logic               locked_q, locked_d;
    logic               busy_q, busy_d;
    logic [DIGIT_W-1:0] dig;
    logic [DIGIT_W-1:0] exp_dig;
    logic               car;

    assign dig = digit_data[i*DIGIT_W +: DIGIT_W];
    assign car = car_detected[i];

    // Passcode digit expected at the current index; index 0 is the MS digit.
    always_comb begin
      exp_dig = '0;
      for (int unsigned d = 0; d < CODE_DIGITS; d++) begin
        if (idx_q == IDX_W'(d)) begin
          exp_dig = PASSCODE[(CODE_DIGITS-1-d)*DIGIT_W +: DIGIT_W];
        end
      end
    end

    always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mis_d   = mis_q;
      gap_d   = gap_q;
      tries_d = tries_q;
      open_d  = open_q;
      lock_d  = lock_q;
      unique case (state_q)
        S_IDLE: begin
          if (car) begin
            state_d = S_ENTRY;
            idx_d   = '0;
            mis_d   = 1'b0;
            gap_d   = '0;
          end
        end
        S_ENTRY: begin
          if (digit_valid[i]) begin
            mis_d = mis_q | (dig != exp_dig);
            gap_d = '0;
            // The final digit takes priority over the car leaving.
            if (idx_q == IDX_LAST) begin
              state_d = S_CHECK;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
              if (!car) state_d = S_IDLE;
            end
          end else if (!car) begin
            state_d = S_IDLE;
          end else if (gap_q == GAP_LAST) begin
            state_d = S_CHECK;
            mis_d   = 1'b1;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (!mis_q) begin
            state_d = S_OPEN;
            tries_d = '0;
            open_d  = '0;
          end else if (tries_q == TRY_LAST) begin
            state_d = S_LOCKOUT;
            tries_d = '0;
            lock_d  = '0;
          end else begin
            tries_d = tries_q + 1'b1;
            if (car) begin
              state_d = S_ENTRY;
              idx_d   = '0;
              mis_d   = 1'b0;
              gap_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_OPEN: begin
          if (open_q == OPN_LAST) begin
            state_d = S_WAIT_CLEAR;
            open_d  = '0;
          end else begin
            open_d = open_q + 1'b1;
          end
        end
        S_WAIT_CLEAR: begin
          if (!car) state_d = S_IDLE;
        end
        S_LOCKOUT: begin
          if (lock_q == LCK_LAST) begin
            state_d = S_IDLE;
            lock_d  = '0;
          end else begin
            lock_d = lock_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Outputs are registered copies of the next-state decode.
      unlock_d = (state_d == S_OPEN);
      locked_d = (state_d == S_LOCKOUT);
      busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= S_IDLE;
        idx_q    <= '0;
        mis_q    <= 1'b0;
        gap_q    <= '0;
        tries_q  <= '0;
        open_q   <= '0;
        lock_q   <= '0;
        unlock_q <= 1'b0;
        locked_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        idx_q    <= idx_d;
        mis_q    <= mis_d;
        gap_q    <= gap_d;
        tries_q  <= tries_d;
        open_q   <= open_d;
        lock_q   <= lock_d;
        unlock_q <= unlock_d;
        locked_q <= locked_d;
        busy_q   <= busy_d;
      end
    end

    assign unlock[i]     = unlock_q;
    assign locked_out[i] = locked_q;
    assign busy[i]       = busy_q;

`ifdef GATE_AUDIT_CNT_EN
    logic [7:0] gcnt_q, gcnt_d;

    always_comb begin
      gcnt_d = gcnt_q;
      if (state_q == S_CHECK && state_d == S_OPEN && gcnt_q != 8'hFF) begin
        gcnt_d = gcnt_q + 8'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) gcnt_q <= '0;
      else     gcnt_q <= gcnt_d;
    end

    assign grant_count[i*8 +: 8] = gcnt_q;
`else
    assign grant_count[i*8 +: 8] = '0;
`endif
  end

endmodule

// File: tb/tb_gate_access_ctrl.sv
// Testbench for gate_access_ctrl: a table of vectors for a basic grant, hand
// sequences for lockout, timeout, wait-clear, reset and car-drop cases, then
// randomized traffic. Every edge is also checked against a per-lane model
// built from digit lists and countdowns.
module tb_gate_access_ctrl;
  localparam int NL = 2;
  localparam int CD = 3;
  localparam int DW = 4;
  localparam int OC = 8;
  localparam int MT = 3;
  localparam int LC = 16;
  localparam int ET = 32;
  localparam logic [CD*DW-1:0] PC = 12'h123;

  logic              clk;
  logic              rst;
  logic [NL-1:0]     car;
  logic [NL-1:0]     dv;
  logic [NL*DW-1:0]  data;
  logic [NL-1:0]     unlock;
  logic [NL-1:0]     locked_out;
  logic [NL-1:0]     busy;
  logic [NL*8-1:0]   grant_count;

  gate_access_ctrl #(
    .N_LANES(NL), .CODE_DIGITS(CD), .DIGIT_W(DW), .PASSCODE(PC),
    .OPEN_CYCLES(OC), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC), .ENTRY_TIMEOUT(ET)
  ) dut (
    .clk(clk), .rst(rst), .car_detected(car), .digit_valid(dv),
    .digit_data(data), .unlock(unlock), .locked_out(locked_out),
    .busy(busy), .grant_count(grant_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: digits collected so far plus remaining-cycle countdowns.
  int m_dig[NL][CD];
  int m_cnt[NL];
  bit m_entering[NL];
  bit m_pending[NL];
  bit m_forced[NL];
  int m_gap[NL];
  int m_open_left[NL];
  bit m_wait[NL];
  int m_lock_left[NL];
  int m_tries[NL];
  int m_grants[NL];

  function automatic int code_digit(int d);
    logic [CD*DW-1:0] p;
    p = PC >> ((CD - 1 - d) * DW);
    return int'(p[DW-1:0]);
  endfunction

  task automatic model_edge();
    for (int l = 0; l < NL; l++) begin
      bit c;
      bit v;
      int dg;
      bit ok;
      c  = car[l];
      v  = dv[l];
      dg = int'(data[l*DW +: DW]);
      if (rst) begin
        m_cnt[l] = 0; m_entering[l] = 0; m_pending[l] = 0; m_forced[l] = 0;
        m_gap[l] = 0; m_open_left[l] = 0; m_wait[l] = 0; m_lock_left[l] = 0;
        m_tries[l] = 0; m_grants[l] = 0;
      end else if (m_pending[l]) begin
        ok = !m_forced[l];
        for (int d = 0; d < CD; d++) if (m_dig[l][d] != code_digit(d)) ok = 0;
        m_pending[l] = 0;
        if (ok) begin
          m_open_left[l] = OC;
          m_tries[l] = 0;
          if (m_grants[l] < 255) m_grants[l]++;
        end else if (m_tries[l] + 1 == MT) begin
          m_lock_left[l] = LC;
          m_tries[l] = 0;
        end else begin
          m_tries[l]++;
          if (c) begin m_entering[l] = 1; m_cnt[l] = 0; m_gap[l] = 0; end
        end
      end else if (m_open_left[l] > 0) begin
        m_open_left[l]--;
        if (m_open_left[l] == 0) m_wait[l] = 1;
      end else if (m_wait[l]) begin
        if (!c) m_wait[l] = 0;
      end else if (m_lock_left[l] > 0) begin
        m_lock_left[l]--;
      end else if (m_entering[l]) begin
        if (v) begin
          m_dig[l][m_cnt[l]] = dg;
          m_cnt[l]++;
          m_gap[l] = 0;
          if (m_cnt[l] == CD) begin
            m_entering[l] = 0; m_pending[l] = 1; m_forced[l] = 0;
          end else if (!c) begin
            m_entering[l] = 0;
          end
        end else if (!c) begin
          m_entering[l] = 0;
        end else begin
          m_gap[l]++;
          if (m_gap[l] == ET) begin
            m_entering[l] = 0; m_pending[l] = 1; m_forced[l] = 1;
          end
        end
      end else if (c) begin
        m_entering[l] = 1; m_cnt[l] = 0; m_gap[l] = 0;
      end
    end
  endtask

  function automatic int exp_grants(int l);
`ifdef GATE_AUDIT_CNT_EN
    return m_grants[l];
`else
    return 0 * l;
`endif
  endfunction

  task automatic check_model(string tag);
    logic [NL-1:0]   eu;
    logic [NL-1:0]   el;
    logic [NL-1:0]   eb;
    logic [NL*8-1:0] eg;
    for (int l = 0; l < NL; l++) begin
      eu[l] = (m_open_left[l] > 0);
      el[l] = (m_lock_left[l] > 0);
      eb[l] = m_entering[l] | m_pending[l] | (m_open_left[l] > 0) | m_wait[l] | (m_lock_left[l] > 0);
      eg[l*8 +: 8] = 8'(exp_grants(l));
    end
    vectors++;
    if (unlock !== eu || locked_out !== el || busy !== eb || grant_count !== eg) begin
      miscompares++;
      $display("FAIL %s t=%0t unlock=%b req %b locked_out=%b req %b busy=%b req %b grant_count=%h req %h",
               tag, $time, unlock, eu, locked_out, el, busy, eb, grant_count, eg);
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic idle(int n, string tag);
    dv = '0;
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic put(logic [NL-1:0] lanes, int d, string tag);
    dv = lanes;
    for (int l = 0; l < NL; l++) data[l*DW +: DW] = DW'(d);
    step(tag);
    dv = '0;
  endtask

  task automatic enter3(logic [NL-1:0] lanes, int a, int b, int c, string tag);
    put(lanes, a, tag);
    put(lanes, b, tag);
    put(lanes, c, tag);
  endtask

  typedef struct {
    logic [1:0] car;
    logic [1:0] dv;
    logic [7:0] data;
    logic [1:0] unlock;
    logic [1:0] lo;
    logic [1:0] busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int lo_cycles;
    logic [7:0] g0;

    // Basic grant on lane 0: unlock rises 2 edges after digit 3, for 8 cycles.
    tbl[0] = '{car: 2'b01, dv: 2'b00, data: 8'h00, unlock: 2'b00, lo: 2'b00, busy: 2'b01};
    tbl[1] = '{car: 2'b01, dv: 2'b01, data: 8'h01, unlock: 2'b00, lo: 2'b00, busy: 2'b01};
    tbl[2] = '{car: 2'b01, dv: 2'b01, data: 8'h02, unlock: 2'b00, lo: 2'b00, busy: 2'b01};
    tbl[3] = '{car: 2'b01, dv: 2'b01, data: 8'h03, unlock: 2'b00, lo: 2'b00, busy: 2'b01};
    for (int k = 4; k < 12; k++)
      tbl[k] = '{car: 2'b01, dv: 2'b00, data: 8'h00, unlock: 2'b01, lo: 2'b00, busy: 2'b01};
    tbl[12] = '{car: 2'b01, dv: 2'b00, data: 8'h00, unlock: 2'b00, lo: 2'b00, busy: 2'b01};
    tbl[13] = '{car: 2'b00, dv: 2'b00, data: 8'h00, unlock: 2'b00, lo: 2'b00, busy: 2'b00};

    rst = 1'b1; car = '0; dv = '0; data = '0;
    step("reset");
    step("reset");
    rst = 1'b0;

    for (int k = 0; k < 14; k++) begin
      car = tbl[k].car; dv = tbl[k].dv; data = tbl[k].data;
      step("table_model");
      vectors++;
      if (unlock !== tbl[k].unlock || locked_out !== tbl[k].lo || busy !== tbl[k].busy) begin
        miscompares++;
        $display("FAIL table[%0d] unlock=%b req %b locked_out=%b req %b busy=%b req %b",
                 k, unlock, tbl[k].unlock, locked_out, tbl[k].lo, busy, tbl[k].busy);
      end
    end
    dv = '0;

    // Three wrong codes with car held -> lockout of exactly LC cycles.
    car = 2'b01;
    step("lock_setup");
    enter3(2'b01, 1, 2, 4, "wrong1");
    step("check1");
    enter3(2'b01, 9, 9, 9, "wrong2");
    step("check2");
    enter3(2'b01, 1, 1, 1, "wrong3");
    lo_cycles = 0;
    for (int k = 0; k < 22; k++) begin
      if (k < 10) begin
        dv = (k % 2 == 0) ? 2'b01 : 2'b00;
        data[DW-1:0] = DW'((k / 2) % 3 + 1);
      end else begin
        dv = '0;
      end
      step("lockout");
      if (locked_out[0]) lo_cycles++;
    end
    dv = '0;
    vectors++;
    if (lo_cycles != LC) begin
      miscompares++;
      $display("FAIL lockout_len got %0d cycles req %0d", lo_cycles, LC);
    end
    // One wrong code after lockout must not lock again; then a good code grants.
    idle(2, "post_lock");
    enter3(2'b01, 5, 5, 5, "wrong_after_lock");
    step("check_after_lock");
    enter3(2'b01, 1, 2, 3, "good_after_lock");
    idle(12, "open_after_lock");
    car = 2'b00;
    idle(2, "clear0");

    // Lane 1 entry timeout counts as a failure; a later good code still grants.
    car = 2'b10;
    step("to_setup");
    put(2'b10, 1, "to_digit");
    idle(ET + 6, "timeout");
    enter3(2'b10, 1, 2, 3, "to_good");
    idle(12, "to_open");
    car = 2'b00;
    idle(2, "clear1");

    // Both lanes in lockstep, then car held in WAIT_CLEAR blocks a second grant.
    car = 2'b11;
    step("both_setup");
    enter3(2'b11, 1, 2, 3, "both_code");
    idle(12, "both_open");
    enter3(2'b11, 1, 2, 3, "wait_clear_code");
    idle(6, "wait_clear");
    car = 2'b00;
    step("drop");
    car = 2'b11;
    step("reassert");
    enter3(2'b11, 1, 2, 3, "regrant");
    idle(12, "regrant_open");
    car = 2'b00;
    idle(2, "clear2");

    // Reset during unlock.
    car = 2'b01;
    step("rst_unlock_setup");
    enter3(2'b01, 1, 2, 3, "rst_unlock_code");
    idle(3, "rst_unlock_open");
    car = 2'b00; rst = 1'b1;
    step("rst_unlock");
    rst = 1'b0;
    vectors++;
    if ({unlock, locked_out, busy, grant_count} !== '0) begin
      miscompares++;
      $display("FAIL rst_in_unlock outputs=%h req 0", {unlock, locked_out, busy, grant_count});
    end

    // Reset during lockout.
    car = 2'b01;
    step("rst_lock_setup");
    enter3(2'b01, 0, 0, 0, "rl1"); step("rl_c1");
    enter3(2'b01, 0, 0, 0, "rl2"); step("rl_c2");
    enter3(2'b01, 0, 0, 0, "rl3");
    idle(4, "rst_lock_wait");
    car = 2'b00; rst = 1'b1;
    step("rst_lock");
    rst = 1'b0;
    vectors++;
    if ({unlock, locked_out, busy, grant_count} !== '0) begin
      miscompares++;
      $display("FAIL rst_in_lockout outputs=%h req 0", {unlock, locked_out, busy, grant_count});
    end

    // Three grants on lane 0 from reset.
    for (int g = 0; g < 3; g++) begin
      car = 2'b01;
      step("grant_setup");
      enter3(2'b01, 1, 2, 3, "grant_code");
      idle(10, "grant_open");
      car = 2'b00;
      idle(2, "grant_clear");
    end
    g0 = grant_count[7:0];
    vectors++;
`ifdef GATE_AUDIT_CNT_EN
    if (g0 !== 8'd3) begin
      miscompares++;
      $display("FAIL grant_count0 got %0d req 3", g0);
    end
`else
    if (g0 !== 8'd0) begin
      miscompares++;
      $display("FAIL grant_count0 got %0d req 0", g0);
    end
`endif

    // Car leaves after two digits: no CHECK, tries kept; later good code grants.
    car = 2'b01;
    step("drop_setup");
    put(2'b01, 1, "drop_d1");
    put(2'b01, 2, "drop_d2");
    car = 2'b00;
    idle(2, "drop_idle");
    car = 2'b01;
    step("drop_return");
    enter3(2'b01, 1, 2, 3, "drop_good");
    idle(12, "drop_open");
    car = 2'b00;
    idle(2, "clear3");

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 1499) == 0);
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(0, 19) == 0) car[l] = ~car[l];
        dv[l] = ($urandom_range(0, 2) == 0);
        data[l*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(1, 3));
      end
      step("random");
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gate_access_ctrl.md
Name: gate_access_ctrl

Overview:
- Parametrised multi-lane gate controller. Each lane is one entry or exit gate with its own car sensor and keypad.
- Digits arrive serially, one per strobe, and are compared against a fixed passcode.
- A correct code drives a timed unlock pulse. Repeated failures trigger a timed lockout.
- Sits between the per-gate sensor/keypad front ends and the barrier actuators; replaces the fixed two-lane, three-digit handler.

Parameters:
- N_LANES, 2, number of independent gate lanes (>=1)
- CODE_DIGITS, 3, digits per code (>=1)
- DIGIT_W, 4, bits per digit
- PASSCODE, 12'h123, code, CODE_DIGITS*DIGIT_W bits; most-significant digit is entered first
- OPEN_CYCLES, 8, cycles unlock stays high per grant (>=1)
- MAX_TRIES, 3, consecutive failures that trigger lockout (>=1)
- LOCKOUT_CYCLES, 16, lockout duration in cycles (>=1)
- ENTRY_TIMEOUT, 32, idle cycles allowed between digits before the attempt fails (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- car_detected  in  N_LANES  per-lane vehicle presence, level
- digit_valid  in  N_LANES  per-lane one-cycle digit strobe
- digit_data  in  N_LANES*DIGIT_W  lane i digit at [i*DIGIT_W +: DIGIT_W]; sampled only with digit_valid[i]
- unlock  out  N_LANES  registered barrier-open command
- locked_out  out  N_LANES  registered lockout indicator
- busy  out  N_LANES  registered; high when the lane is in any state other than IDLE
- grant_count  out  N_LANES*8  per-lane grant counter (see Optional Feature)

Behaviour:
- Lanes are fully independent. No shared state and no arbitration.
- Reset: on any clk edge with rst=1, every lane goes to IDLE and the following clear to 0: unlock, locked_out, busy, digit index, mismatch flag, try counter, all timers, grant_count. Reset mid-operation aborts the attempt, unlock, or lockout immediately.
- Per-lane FSM states: IDLE, ENTRY, CHECK, OPEN, WAIT_CLEAR, LOCKOUT.
- IDLE:
  - digit_valid is ignored.
  - car_detected=1 -> ENTRY; index, mismatch flag, and gap timer are cleared.
- ENTRY:
  - On each digit_valid, compare the digit with PASSCODE digit[index] and OR any mismatch into the flag; index++; gap timer resets.
  - When the CODE_DIGITS-th digit is accepted -> CHECK.
  - Gap timer reaches ENTRY_TIMEOUT without a strobe -> CHECK with the mismatch flag forced to 1.
  - car_detected=0 (and no final digit this cycle) -> IDLE. The attempt is discarded and the try counter is kept.
  - A final digit and car_detected=0 in the same cycle: the digit wins; go to CHECK.
- CHECK (exactly 1 cycle):
  - Match -> OPEN; try counter cleared.
  - Mismatch: tries+1 == MAX_TRIES -> LOCKOUT, tries cleared.
  - Otherwise tries++; -> ENTRY if car_detected=1, else IDLE.
- OPEN:
  - unlock=1 for exactly OPEN_CYCLES cycles, then -> WAIT_CLEAR.
  - car_detected is ignored in this state.
- WAIT_CLEAR:
  - unlock=0; digits ignored.
  - car_detected=0 -> IDLE. This prevents one car earning two grants.
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYCLES cycles; all digits ignored; then -> IDLE.
- Latency: final digit sampled at edge k -> CHECK after edge k -> unlock high after edge k+1, for OPEN_CYCLES cycles.
- A mismatching digit does not abort entry. All CODE_DIGITS digits are always consumed, so failure is not revealed early.
- Timer widths are $clog2(param+1). There is no wrap-around: timers saturate or clear on state exit.

Optional Feature:
- Macro: GATE_AUDIT_CNT_EN.
- Defined:
  - grant_count lane i is an 8-bit counter, incremented on each CHECK->OPEN transition.
  - It saturates at 255 and is cleared by rst.
- Undefined:
  - No counter logic is built; grant_count is driven constant 0.
  - Port list is identical in both cases.

Test Plan:
- Defaults. Lane0: car=1, digits 1,2,3 on consecutive cycles -> unlock[0] high 2 edges after digit 3, for exactly 8 cycles; busy[0]=1; lane1 outputs stay 0.
- Lane0: wrong codes 1,2,4 then 9,9,9 then 1,1,1, car held -> no unlock; locked_out[0]=1 for exactly 16 cycles starting 1 edge after the third CHECK; digits sent during lockout are ignored; then IDLE with tries=0.
- Lane1: car=1, digit 1, then no strobe for 32 cycles -> counted as a failure, tries=1, FSM back in ENTRY; a subsequent 1,2,3 -> unlock[1] pulse.
- Both lanes enter 1,2,3 in the same cycles -> identical unlock pulses on both lanes. Then car held high after OPEN -> lane stays in WAIT_CLEAR and fresh digits 1,2,3 produce no unlock until car drops and re-asserts.
- rst=1 asserted during unlock and during lockout -> all outputs 0 after that edge. With GATE_AUDIT_CNT_EN defined, 3 grants -> grant_count lane0 = 3; undefined -> 0.
- Lane0: car drops after digit 2 -> IDLE with no CHECK and tries unchanged; car returns and 1,2,3 entered -> unlock.
